// File: rtl/gen_stream_pkg.sv
// Shared definitions for the generator-stream sink and its pacing helper.
//   sink_state_t : sink control states
//   DEF_*        : default widths for the sink's data, accumulator and counter
//   add_ovf      : two's-complement add overflow from the three sign bits
package gen_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } sink_state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_CNT_WIDTH = 16;

    // a, b: operand sign bits; s: result sign bit.
    function automatic logic add_ovf(input logic a, input logic b, input logic s);
        return (a == b) && (s != a);
    endfunction

endpackage

// File: rtl/stall_pacer.sv
// Ready pacer: after each accepted beat, holds ready low for STALL cycles.
//   _clock  : clock, rising edge
//   _reset  : asynchronous active-low reset
//   enable  : the consumer will be accepting in the coming cycle
//   accept  : a beat is being accepted on this edge
//   ready   : registered ready, low while the stall counter is non-zero
module stall_pacer
    import gen_stream_pkg::*;
#(
    parameter int STALL = 0
) (
    input  logic _clock,
    input  logic _reset,
    input  logic enable,
    input  logic accept,
    output logic ready
);

    localparam int CW = (STALL > 0) ? $clog2(STALL + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter is forced to zero whenever pacing is disabled, so every
    // enabled period starts ready.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = CW'(STALL);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            cnt_q <= '0;
            ready <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ready <= enable && (cnt_d == '0);
        end
    end

endmodule

// File: rtl/gen_stream_sink.sv
// Consumer for the generator handshake: launches the generator, drains its
// stream (including the beat arriving with gen_done) and reduces the beats to
// sum / count / min / max. Completion is reported via _start/_done.
//   _clock, _reset         : clock (rising) and asynchronous active-low reset
//   _start, _done, busy    : caller handshake and activity flag
//   gen_start, gen_ready   : launch pulse and ready towards the generator
//   gen_valid, gen_done,
//   gen_data               : generator stream
//   sum, count, min_val,
//   max_val, overflow,
//   timeout                : results, held while _done is high
module gen_stream_sink
    import gen_stream_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int STALL      = 0,
    parameter int MAX_CYCLES = 1024
) (
    input  logic                        _clock,
    input  logic                        _reset,
    input  logic                        _start,
    output logic                        _done,
    output logic                        busy,
    output logic                        gen_start,
    output logic                        gen_ready,
    input  logic                        gen_valid,
    input  logic                        gen_done,
    input  logic signed [WIDTH-1:0]     gen_data,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic        [CNT_WIDTH-1:0] count,
    output logic signed [WIDTH-1:0]     min_val,
    output logic signed [WIDTH-1:0]     max_val,
    output logic                        overflow,
    output logic                        timeout
);

    localparam int CYC_W = (MAX_CYCLES > 0) ? $clog2(MAX_CYCLES + 1) : 1;

    sink_state_t state_q;
    sink_state_t state_d;

    logic [CYC_W-1:0]            cyc_q;
    logic                        start_ok;
    logic                        running;
    logic                        accept;
    logic                        term_done;
    logic                        tmo_hit;
    logic signed [ACC_WIDTH-1:0] data_ext;
    logic signed [ACC_WIDTH-1:0] sum_d;

    assign start_ok  = _start && ((state_q == IDLE) || (state_q == FINISH));
    assign running   = (state_q == RUN);
    assign accept    = running && gen_valid && gen_ready;
    // gen_done is only sampled while ready; otherwise it is simply waited on.
    assign term_done = running && gen_done && gen_ready;
    assign tmo_hit   = running && (MAX_CYCLES != 0) &&
                       ((cyc_q + CYC_W'(1)) == CYC_W'(MAX_CYCLES));
    assign data_ext  = ACC_WIDTH'(gen_data);
    assign sum_d     = sum + data_ext;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = LAUNCH;
            LAUNCH:  state_d = RUN;
            RUN:     if (term_done || tmo_hit) state_d = FINISH;
            FINISH:  if (start_ok) state_d = LAUNCH;
            default: state_d = IDLE;
        endcase
    end

    // Ready is registered, so the pacer is told whether the next cycle is RUN.
    stall_pacer #(
        .STALL (STALL)
    ) u_pacer (
        ._clock (_clock),
        ._reset (_reset),
        .enable (state_d == RUN),
        .accept (accept),
        .ready  (gen_ready)
    );

    // Control: state, handshake outputs, run-cycle counter, timeout flag.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_q   <= IDLE;
            _done     <= 1'b0;
            busy      <= 1'b0;
            gen_start <= 1'b0;
            cyc_q     <= '0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            _done     <= (state_d == FINISH);
            busy      <= (state_d == LAUNCH) || (state_d == RUN);
            gen_start <= (state_d == LAUNCH);
            if (start_ok) begin
                cyc_q   <= '0;
                timeout <= 1'b0;
            end else if (running) begin
                cyc_q <= cyc_q + CYC_W'(1);
                // A clean gen_done termination on the same edge takes precedence.
                if (tmo_hit && !term_done) timeout <= 1'b1;
            end
        end
    end

    // Reduction of accepted beats.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            sum      <= '0;
            count    <= '0;
            min_val  <= '0;
            max_val  <= '0;
            overflow <= 1'b0;
        end else if (start_ok) begin
            sum      <= '0;
            count    <= '0;
            min_val  <= '0;
            max_val  <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            sum <= sum_d;
            if (add_ovf(sum[ACC_WIDTH-1], data_ext[ACC_WIDTH-1], sum_d[ACC_WIDTH-1]))
                overflow <= 1'b1;
            if (count != '1) count <= count + CNT_WIDTH'(1);
            // An empty count means this is the first beat: load both extremes.
            if ((count == '0) || (gen_data < min_val)) min_val <= gen_data;
            if ((count == '0) || (gen_data > max_val)) max_val <= gen_data;
        end
    end

endmodule

// File: tb/tb_gen_stream_sink.sv
module tb_gen_stream_sink;

    typedef struct {
        int               inst;
        int               n;
        logic [4:0][31:0] b;
        logic [31:0]      e_sum;
        int               e_cnt;
        logic [31:0]      e_min;
        logic [31:0]      e_max;
        logic             e_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        int          cnt;
        logic [31:0] mn;
        logic [31:0] mx;
        logic        ovf;
        logic        tmo;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start   [2];
    logic        gvalid  [2];
    logic        gdone   [2];
    logic [31:0] gdata   [2];
    logic        done_o  [2];
    logic        busy_o  [2];
    logic        gstart_o[2];
    logic        gready_o[2];
    logic [31:0] sum_o   [2];
    logic [15:0] cnt_o   [2];
    logic [31:0] min_o   [2];
    logic [31:0] max_o   [2];
    logic        ovf_o   [2];
    logic        tmo_o   [2];

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    // Instance 0: always ready; instance 1: two stall cycles per beat.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        gen_stream_sink #(
            .WIDTH      (32),
            .ACC_WIDTH  (32),
            .CNT_WIDTH  (16),
            .STALL      ((g == 0) ? 0 : 2),
            .MAX_CYCLES (100)
        ) u_dut (
            ._clock    (clk),
            ._reset    (rst_n),
            ._start    (start[g]),
            ._done     (done_o[g]),
            .busy      (busy_o[g]),
            .gen_start (gstart_o[g]),
            .gen_ready (gready_o[g]),
            .gen_valid (gvalid[g]),
            .gen_done  (gdone[g]),
            .gen_data  (gdata[g]),
            .sum       (sum_o[g]),
            .count     (cnt_o[g]),
            .min_val   (min_o[g]),
            .max_val   (max_o[g]),
            .overflow  (ovf_o[g]),
            .timeout   (tmo_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_done"},  {31'b0, done_o[k]},   0);
        check({tag, "_busy"},  {31'b0, busy_o[k]},   0);
        check({tag, "_gstart"},{31'b0, gstart_o[k]}, 0);
        check({tag, "_gready"},{31'b0, gready_o[k]}, 0);
        check({tag, "_sum"},   sum_o[k],             0);
        check({tag, "_count"}, {16'b0, cnt_o[k]},    0);
        check({tag, "_min"},   min_o[k],             0);
        check({tag, "_max"},   max_o[k],             0);
        check({tag, "_ovf"},   {31'b0, ovf_o[k]},    0);
        check({tag, "_tmo"},   {31'b0, tmo_o[k]},    0);
    endtask

    task automatic compare_results(input int k);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = exp_q.pop_front();
        check("res_sum",   sum_o[k],             e.sum);
        check("res_count", {16'b0, cnt_o[k]},    e.cnt);
        check("res_min",   min_o[k],             e.mn);
        check("res_max",   max_o[k],             e.mx);
        check("res_ovf",   {31'b0, ovf_o[k]},    {31'b0, e.ovf});
        check("res_tmo",   {31'b0, tmo_o[k]},    {31'b0, e.tmo});
    endtask

    task automatic launch(input int k);
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        check("gen_start", {31'b0, gstart_o[k]}, 1);
        check("done_clr",  {31'b0, done_o[k]},   0);
        check("busy_run",  {31'b0, busy_o[k]},   1);
    endtask

    // Generator model: presents beats in order, raises gen_done with the
    // last one and holds data until it is taken. abort_after >= 0 stops
    // driving once that many beats have been accepted.
    task automatic run_stream(input int k, input int n, input logic [4:0][31:0] b,
                              input int abort_after);
        int   idx = 0;
        int   low_run = 0;
        int   cyc = 0;
        bit   after_beat = 0;
        bit   fin = 0;
        logic hs;
        launch(k);
        while (!fin) begin
            if (abort_after >= 0 && idx == abort_after) return;
            gvalid[k] = (idx < n);
            gdata[k]  = (idx < n) ? b[idx] : 32'd0;
            gdone[k]  = (idx >= n - 1);
            hs = gready_o[k];
            if (hs) begin
                if (after_beat) check("stall_gap", low_run, (k == 0) ? 0 : 2);
                after_beat = 0;
                low_run    = 0;
            end else begin
                low_run++;
            end
            @(negedge clk);
            cyc++;
            if (hs) begin
                if (gvalid[k]) begin
                    idx++;
                    after_beat = 1;
                    low_run    = 0;
                end
                if (gdone[k]) fin = 1;
            end
            if (!fin && cyc > 300) begin
                check("stream_bound", 0, 1);
                break;
            end
        end
        check("done_latency", {31'b0, done_o[k]}, 1);
        check("busy_idle",    {31'b0, busy_o[k]}, 0);
        check("beats_sent",   idx, n);
        gvalid[k] = 1'b0;
        gdone[k]  = 1'b0;
        compare_results(k);
    endtask

    task automatic mk(input int inst, input int n,
                      input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                      input logic [31:0] b3, input logic [31:0] b4,
                      input logic [31:0] s, input int c, input logic [31:0] mn,
                      input logic [31:0] mx, input logic ov);
        vec_t v;
        v.inst = inst; v.n = n;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
        v.e_sum = s; v.e_cnt = c; v.e_min = mn; v.e_max = mx; v.e_ovf = ov;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [31:0] s, input int c, input logic [31:0] mn,
                            input logic [31:0] mx, input logic ov, input logic tm);
        exp_t e;
        e.sum = s; e.cnt = c; e.mn = mn; e.mx = mx; e.ovf = ov; e.tmo = tm;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [4:0][31:0] bb;
        int waits;

        mk(0, 5, 0, 2, 4, 6, 8,                20, 5, 0, 8, 0);
        mk(1, 5, 0, 2, 4, 6, 8,                20, 5, 0, 8, 0);
        mk(0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0);
        mk(0, 2, 32'h7FFFFFFF, 1, 0, 0, 0,     32'h80000000, 2, 1, 32'h7FFFFFFF, 1);
        mk(0, 3, 32'h7FFFFFFF, 1, 32'hFFFFFFFF, 0, 0,
                                              32'h7FFFFFFF, 3, 32'hFFFFFFFF, 32'h7FFFFFFF, 1);
        mk(0, 2, 1, 2, 0, 0, 0,                3, 2, 1, 2, 0);
        mk(1, 3, -3, 10, -7, 0, 0,             0, 3, -7, 10, 0);
        mk(1, 1, -100, 0, 0, 0, 0,             -100, 1, -100, -100, 0);

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; gvalid[k] = 1'b0; gdone[k] = 1'b0; gdata[k] = '0;
        end
        repeat (2) @(negedge clk);
        check_zero(0, "rst0");
        check_zero(1, "rst1");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero(0, "idle0");

        for (int i = 0; i < vecs.size(); i++) begin
            push_exp(vecs[i].e_sum, vecs[i].e_cnt, vecs[i].e_min, vecs[i].e_max,
                     vecs[i].e_ovf, 1'b0);
            run_stream(vecs[i].inst, vecs[i].n, vecs[i].b, -1);
        end

        // Generator that never finishes: timeout after 100 RUN cycles.
        push_exp(0, 0, 0, 0, 1'b0, 1'b1);
        launch(0);
        waits = 0;
        while (!done_o[0] && waits < 150) begin
            @(negedge clk);
            waits++;
        end
        check("timeout_cycles", waits, 101);
        compare_results(0);

        // Asynchronous reset in the middle of a stream.
        bb[0] = 0; bb[1] = 2; bb[2] = 4; bb[3] = 6; bb[4] = 8;
        run_stream(0, 5, bb, 3);
        check("pre_rst_sum",   sum_o[0],          6);
        check("pre_rst_count", {16'b0, cnt_o[0]}, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(0, "async");
        @(negedge clk);
        gvalid[0] = 1'b0; gdone[0] = 1'b0;
        rst_n = 1'b1;
        bb[0] = -5; bb[1] = 7; bb[2] = 0; bb[3] = 0; bb[4] = 0;
        push_exp(2, 2, -5, 7, 1'b0, 1'b0);
        run_stream(0, 2, bb, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gen_stream_sink.md
Name: gen_stream_sink

Overview:
Consumer end of the team's generator handshake (`_start`/`_ready`/`_valid`/`_done`/`_0`). It launches an attached generator module and drains its stream, including the beat that arrives together with `_done`. It reduces the beats to sum/count/min/max and reports completion to its own caller through a start/done pair. It is used as a synthesizable sink for generator blocks and as a backpressure stimulus: a programmable stall pattern on `gen_ready`.

Parameters:
- `WIDTH`, 32: signed data width of `gen_data`, `min_val` and `max_val`.
- `ACC_WIDTH`, 32: signed width of the `sum` accumulator.
- `CNT_WIDTH`, 16: width of the beat counter.
- `STALL`, 0: cycles `gen_ready` is held low after each accepted beat; 0 = always ready while running.
- `MAX_CYCLES`, 1024: RUN-state cycle limit before forced termination; 0 disables the timeout.

Ports:
- `_clock`  in  1  — single clock, rising edge.
- `_reset`  in  1  — asynchronous, active-low reset.
- `_start`  in  1  — caller pulse; accepted only in IDLE or FINISH.
- `_done`  out  1  — results valid; held until the next accepted `_start`.
- `busy`  out  1  — high in LAUNCH and RUN.
- `gen_start`  out  1  — one-cycle start pulse to the generator.
- `gen_ready`  out  1  — sink ready to the generator.
- `gen_valid`  in  1  — generator output valid.
- `gen_done`  in  1  — generator finished.
- `gen_data`  in  `WIDTH`  — generator output (`_0`), signed.
- `sum`  out  `ACC_WIDTH`  — signed wrap-around sum of accepted beats.
- `count`  out  `CNT_WIDTH`  — accepted beats; saturates at all-ones.
- `min_val`  out  `WIDTH`  — smallest accepted value; 0 if `count` = 0.
- `max_val`  out  `WIDTH`  — largest accepted value; 0 if `count` = 0.
- `overflow`  out  1  — sticky; set on signed overflow of `sum`.
- `timeout`  out  1  — set when the run was ended by `MAX_CYCLES`.

Behaviour:
- Reset (`_reset` = 0, asynchronous):
  - state = IDLE.
  - All outputs 0, including `_done`, `gen_start`, `gen_ready`, `busy`, `sum`, `count`, `min_val`, `max_val`, `overflow`, `timeout`.
  - Mid-run reset abandons the stream; the generator is not notified.
- States: IDLE, LAUNCH, RUN, FINISH. All outputs are registered.
- IDLE/FINISH + `_start` = 1:
  - Go to LAUNCH.
  - Clear `_done`, `sum`, `count`, `overflow`, `timeout`, `min_val`, `max_val`, the stall counter and the cycle counter.
- LAUNCH:
  - `gen_start` = 1 for exactly this one cycle; `gen_ready` = 0.
  - Next state is RUN unconditionally.
- RUN, ready generation:
  - `gen_ready` = 1 unless the stall counter is non-zero.
  - On each accepted beat the stall counter loads `STALL` and then decrements once per cycle while `gen_ready` = 0.
- RUN, beat acceptance (`gen_valid` and `gen_ready` both 1 at a rising edge):
  - `sum` += `gen_data` (sign-extended), wrapping.
  - `overflow` is set if the operands have the same sign and the result sign differs.
  - `count` increments, saturating at all-ones.
  - `min_val`/`max_val` are updated; the first beat loads both.
- RUN, termination:
  - `gen_done` and `gen_ready` both 1 at an edge → FINISH.
  - A beat with `gen_valid` = 1 in that same cycle is accepted first.
  - `gen_done` while `gen_ready` = 0 is not sampled and is waited on.
- RUN, timeout:
  - The cycle counter increments every RUN cycle.
  - When it reaches `MAX_CYCLES` (if non-zero) → FINISH with `timeout` = 1.
  - A beat accepted on that same edge is still counted.
- FINISH:
  - `_done` = 1, `gen_ready` = 0, results are held stable.
  - `_start` restarts via LAUNCH; `_done` drops on the edge that accepts `_start`.
- `_start` in LAUNCH or RUN is ignored.
- `busy` = (state ∈ {LAUNCH, RUN}).
- Latency:
  - `_start` edge → `gen_start` high in the next cycle.
  - Terminating handshake edge → `_done` high in the next cycle, with final results visible.
- `gen_valid`/`gen_data` are ignored outside RUN.

Decomposition:
- Package `gen_stream_pkg`:
  - `sink_state_t` enum (IDLE, LAUNCH, RUN, FINISH).
  - Default width localparams.
  - Function `add_ovf(a, b, s)` returning the signed-overflow bit.
- Sub-module `stall_pacer`:
  - Parameter `STALL`.
  - Inputs: `_clock`, `_reset`, `enable`, `accept`.
  - Output: `ready`.
  - Owns the stall counter; also reused by upstream throttling benches.

Test Plan:
- Generator model emits 0,2,4,6,8 (the base 0, limit 10, step 2 range), `gen_done` with the last beat, `STALL` = 0 → `sum` = 20, `count` = 5, `min_val` = 0, `max_val` = 8, `overflow` = 0, `timeout` = 0; `_done` high one cycle after the last beat.
- Same stream, `STALL` = 2 → identical results; `gen_ready` is low for exactly 2 cycles after each beat; no beat is lost or duplicated; the model holds data while not ready.
- Empty stream, `gen_done` = 1 on the first RUN cycle with `gen_valid` = 0 → `count` = 0, `sum` = 0, `min_val` = `max_val` = 0, `_done` = 1.
- `WIDTH` = `ACC_WIDTH` = 32, beats 0x7FFFFFFF, 1 → `sum` = 0x80000000, `overflow` = 1; a further beat of −1 leaves `overflow` at 1.
- Generator never asserts `gen_done`, `MAX_CYCLES` = 100 → FINISH after 100 RUN cycles, `timeout` = 1, `_done` = 1.
- Reset pulsed low mid-RUN after 3 beats → all outputs 0 immediately (asynchronous); a subsequent `_start` with stream −5,7 gives `sum` = 2, `min_val` = −5, `max_val` = 7, `count` = 2.
